// File: rtl/alu_op_sequencer.sv
// Bring-up driver for the 8-bit ALU: walks opcodes 0..OP_LAST on one operand pair,
// captures each result and checks it against a built-in golden model.
module alu_op_sequencer #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [2:0] OP_LAST       = 3'b110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    output logic [2:0] res_op,
    output logic [7:0] res_data,
    output logic [7:0] res_expected,
    output logic       mismatch,
    output logic [3:0] err_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DRIVE, REPORT, FINISH} state_t;

    localparam logic [3:0] SLAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic [7:0] golden;
    logic       settled;

    assign settled = (cnt == SLAST);

    always_comb begin
        golden = 8'h00;
        unique case (alu_op)
            3'b000:  golden = ~alu_a;
            3'b001:  golden = alu_a | alu_b;
            3'b010:  golden = alu_a ^ alu_b;
            3'b011:  golden = alu_a & alu_b;
            3'b100:  golden = {4'b0, alu_a[3:0]} * {4'b0, alu_b[3:0]};
            3'b101:  golden = alu_a + alu_b;
            3'b110:  golden = alu_a - alu_b;
            default: golden = 8'h00;
        endcase
    end

    always_comb begin
        state_nx  = state;
        res_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (settled) state_nx = REPORT;
            end
            REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                state_nx  = (alu_op == OP_LAST) ? FINISH : DRIVE;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mismatch = res_valid && (res_data != res_expected);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_op       <= 3'b000;
            res_op       <= 3'b000;
            res_data     <= 8'h00;
            res_expected <= 8'h00;
            err_count    <= 4'd0;
            cnt          <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        alu_a     <= a_in;
                        alu_b     <= b_in;
                        alu_op    <= 3'b000;
                        err_count <= 4'd0;
                        cnt       <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (settled) begin
                        res_data     <= alu_out;
                        res_expected <= golden;
                        res_op       <= alu_op;
                        cnt          <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                REPORT: begin
                    if (mismatch && err_count != 4'd15)
                        err_count <= err_count + 4'd1;
                    if (alu_op != OP_LAST)
                        alu_op <= alu_op + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (settle 1 and 3)
// each driven by a behavioural ALU; the settle-1 ALU can fault op 101.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic       start1, start3, fault5;
    logic [7:0] a1, b1, a3, b3;
    logic [7:0] alu_a1, alu_b1, alu_out1, res_data1, res_exp1;
    logic [7:0] alu_a3, alu_b3, alu_out3, res_data3, res_exp3;
    logic [2:0] alu_op1, res_op1, alu_op3, res_op3;
    logic [3:0] err1, err3;
    logic       rv1, mm1, busy1, done1, rv3, mm3, busy3, done3;

    function automatic logic [7:0] alu_model(input logic [7:0] a, b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return {4'b0, a[3:0]} * {4'b0, b[3:0]};
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out1 = (fault5 && alu_op1 == 3'd5) ? 8'h00
                    : alu_model(alu_a1, alu_b1, alu_op1);
    assign alu_out3 = alu_model(alu_a3, alu_b3, alu_op3);

    alu_op_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_out(alu_out1), .res_valid(rv1), .res_op(res_op1),
        .res_data(res_data1), .res_expected(res_exp1),
        .mismatch(mm1), .err_count(err1), .busy(busy1), .done(done1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_out(alu_out3), .res_valid(rv3), .res_op(res_op3),
        .res_data(res_data3), .res_expected(res_exp3),
        .mismatch(mm3), .err_count(err3), .busy(busy3), .done(done3)
    );

    localparam logic [55:0] EXP_F0 = {8'hE1, 8'hFF, 8'h00, 8'h00,
                                      8'hFF, 8'hFF, 8'h0F};
    localparam logic [55:0] EXP_23 = {8'hDE, 8'h68, 8'h0F, 8'h01,
                                      8'h66, 8'h67, 8'hDC};
    localparam logic [55:0] EXP_FF = {8'h00, 8'hFE, 8'hE1, 8'hFF,
                                      8'h00, 8'hFF, 8'h00};

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({alu_a1, alu_b1, alu_op1, res_op1, res_data1, res_exp1} !== '0) begin
            fails++;
            $display("FAIL reset_u1_data got %h exp 0",
                     {alu_a1, alu_b1, alu_op1, res_op1, res_data1, res_exp1});
        end
        tests++;
        if ({rv1, mm1, err1, busy1, done1} !== '0) begin
            fails++;
            $display("FAIL reset_u1_ctrl got %b exp 0",
                     {rv1, mm1, err1, busy1, done1});
        end
        tests++;
        if ({alu_a3, alu_b3, alu_op3, res_op3, res_data3, res_exp3,
             rv3, mm3, err3, busy3, done3} !== '0) begin
            fails++;
            $display("FAIL reset_u3 got %h exp 0",
                     {alu_a3, alu_b3, alu_op3, res_op3, res_data3, res_exp3,
                      rv3, mm3, err3, busy3, done3});
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence(input string name, input logic [7:0] a, b,
                                 input logic [55:0] exp, input int bad);
        int         k;
        logic [7:0] e, d;
        logic       ev;
        fault5 = (bad == 5);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b;
        @(negedge clk);
        start1 = 1'b0; a1 = ~a; b1 = ~b;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            ev = (c % 2 == 0) && (c <= 14);
            tests++;
            if (rv1 !== ev) begin
                fails++;
                $display("FAIL %s res_valid c=%0d got %b exp %b", name, c, rv1, ev);
            end
            tests++;
            if (busy1 !== (c <= 14) || done1 !== (c == 15)) begin
                fails++;
                $display("FAIL %s busy/done c=%0d got %b%b exp %b%b",
                         name, c, busy1, done1, c <= 14, c == 15);
            end
            tests++;
            if (alu_a1 !== a || alu_b1 !== b) begin
                fails++;
                $display("FAIL %s operands c=%0d got %h/%h exp %h/%h",
                         name, c, alu_a1, alu_b1, a, b);
            end
            if (ev) begin
                k = c / 2 - 1;
                e = exp[8*k +: 8];
                d = (k == bad) ? 8'h00 : e;
                tests++;
                if (res_op1 !== 3'(k) || res_data1 !== d || res_exp1 !== e) begin
                    fails++;
                    $display("FAIL %s report op%0d got op%0d %h/%h exp op%0d %h/%h",
                             name, k, res_op1, res_data1, res_exp1, k, d, e);
                end
                tests++;
                if (mm1 !== (k == bad)) begin
                    fails++;
                    $display("FAIL %s mismatch op%0d got %b exp %b",
                             name, k, mm1, k == bad);
                end
            end
        end
        tests++;
        if (err1 !== ((bad < 7) ? 4'd1 : 4'd0)) begin
            fails++;
            $display("FAIL %s err_count got %0d exp %0d",
                     name, err1, (bad < 7) ? 1 : 0);
        end
        fault5 = 1'b0;
    endtask

    task automatic test_settle3();
        logic [2:0] op;
        @(negedge clk);
        start3 = 1'b1; a3 = 8'h23; b3 = 8'h45;
        @(negedge clk);
        start3 = 1'b0; a3 = 8'hAA; b3 = 8'h55;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            op = (c <= 28) ? 3'((c - 1) / 4) : 3'd6;
            tests++;
            if (alu_op3 !== op || alu_a3 !== 8'h23 || alu_b3 !== 8'h45) begin
                fails++;
                $display("FAIL s3_drive c=%0d got op%0d %h/%h exp op%0d 23/45",
                         c, alu_op3, alu_a3, alu_b3, op);
            end
            tests++;
            if (rv3 !== (c % 4 == 0 && c <= 28) || done3 !== (c == 29)
                || busy3 !== (c <= 28)) begin
                fails++;
                $display("FAIL s3_ctrl c=%0d got v%b d%b b%b", c, rv3, done3, busy3);
            end
            if (c % 4 == 0 && c <= 28) begin
                tests++;
                if (res_data3 !== EXP_23[8*(c/4-1) +: 8] || mm3 !== 1'b0) begin
                    fails++;
                    $display("FAIL s3_report c=%0d got %h mm%b exp %h mm0",
                             c, res_data3, mm3, EXP_23[8*(c/4-1) +: 8]);
                end
            end
            start3 = (c == 5 || c == 29);
        end
        start3 = 1'b0;
    endtask

    task automatic test_abort();
        @(negedge clk);
        start1 = 1'b1; a1 = 8'h23; b1 = 8'h45;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (alu_op1 !== 3'd3 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre got op%0d busy%b exp op3 busy1", alu_op1, busy1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({alu_a1, alu_b1, alu_op1, res_op1, res_data1, res_exp1,
             rv1, mm1, err1, busy1, done1} !== '0) begin
            fails++;
            $display("FAIL abort_reset got %h exp 0",
                     {alu_a1, alu_b1, alu_op1, res_op1, res_data1, res_exp1,
                      rv1, mm1, err1, busy1, done1});
        end
        @(negedge clk);
        tests++;
        if ({rv1, done1, busy1} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle got %b exp 000", {rv1, done1, busy1});
        end
    endtask

    initial begin
        rst = 1'b0; start1 = 1'b0; start3 = 1'b0; fault5 = 1'b0;
        a1 = 8'h00; b1 = 8'h00; a3 = 8'h00; b3 = 8'h00;
        test_reset();
        test_sequence("f0_0f", 8'hF0, 8'h0F, EXP_F0, 7);
        test_sequence("23_45", 8'h23, 8'h45, EXP_23, 7);
        test_sequence("stuck_add", 8'h23, 8'h45, EXP_23, 5);
        test_sequence("ff_ff", 8'hFF, 8'hFF, EXP_FF, 7);
        test_settle3();
        test_abort();
        test_sequence("after_abort", 8'h23, 8'h45, EXP_23, 7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Driver end of the 8-bit ALU operand/opcode interface (A, B, op in; out back).
- On a start pulse it latches one operand pair, steps the ALU through opcodes 000..110, holds each for a programmable settle time, and captures the ALU result.
- Checks each capture against an internal golden model and reports per-op results plus an error count.
- Replaces manual delay-and-print stimulus with a synthesizable, self-checking bring-up block.

Parameters:
- SETTLE_CYCLES, 1, cycles operands/op are held before alu_out is sampled; legal range 1..15.
- OP_LAST, 3'b110, last opcode issued; sequence always starts at 3'b000.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a sequence; honoured only when busy=0
- a_in  input  8  operand A, latched on accepted start
- b_in  input  8  operand B, latched on accepted start
- alu_a  output  8  operand A driven to the ALU
- alu_b  output  8  operand B driven to the ALU
- alu_op  output  3  opcode driven to the ALU
- alu_out  input  8  ALU result, combinational from alu_a/alu_b/alu_op
- res_valid  output  1  one-cycle strobe; res_* fields valid
- res_op  output  3  opcode of the reported result
- res_data  output  8  captured alu_out
- res_expected  output  8  golden-model value for res_op
- mismatch  output  1  res_data != res_expected; qualified by res_valid
- err_count  output  4  mismatches this sequence, saturates at 15
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last report

Behaviour:
- Reset values: all outputs 0 (alu_a, alu_b, alu_op, res_*, err_count, busy, done, mismatch). FSM goes to IDLE; the settle counter clears.
- FSM states: IDLE, DRIVE, REPORT, FINISH.
- IDLE:
  - start=1 latches a_in/b_in into alu_a/alu_b, sets alu_op=000, clears err_count, sets busy=1, and moves to DRIVE.
  - start=0 holds.
- DRIVE:
  - Lasts exactly SETTLE_CYCLES cycles; alu_a, alu_b and alu_op are stable throughout.
  - On the final DRIVE cycle, alu_out is registered into res_data and the golden value into res_expected. Moves to REPORT.
- REPORT (one cycle):
  - res_valid=1 with res_op=alu_op; mismatch=(res_data!=res_expected).
  - err_count increments on mismatch, saturating at 15.
  - If alu_op==OP_LAST, moves to FINISH; otherwise alu_op increments and the FSM returns to DRIVE.
- FINISH (one cycle): done=1, busy=0, then IDLE. alu_a, alu_b and alu_op keep their last values.
- res_valid, mismatch and done are 0 in every cycle not listed above. res_data, res_expected and res_op hold between reports.
- Golden model, all results 8 bits (carry and borrow discarded):
  - 000: ~A
  - 001: A|B
  - 010: A^B
  - 011: A&B
  - 100: {4'b0,A[3:0]}*{4'b0,B[3:0]}, max 8'hE1
  - 101: (A+B) mod 256
  - 110: (A-B) mod 256
  - 111: never issued
- Timing: each op takes SETTLE_CYCLES+1 cycles. With start accepted at cycle 0 and S=SETTLE_CYCLES:
  - first res_valid at cycle S+1;
  - op k reported at cycle (k+1)(S+1);
  - done at cycle 7(S+1)+1.
- start while busy=1 (including in the FINISH cycle) is ignored; it does not relatch operands or restart.
- start held high continuously: a new sequence begins on the first IDLE cycle.
- rst mid-sequence: immediate return to IDLE with reset values; no res_valid or done is emitted for the aborted run.
- a_in/b_in changes while busy have no effect.

Test Plan:
- S=1, start with A=8'hF0, B=8'h0F, correct ALU → reports 0F, FF, FF, 00, 00, FF, E1 for ops 0..6 at cycles 2, 4, …, 14; mismatch always 0; done at cycle 15; err_count=0.
- S=1, A=8'h23, B=8'h45 → 8'hDC, 8'h67, 8'h66, 8'h01, 8'h0F, 8'h68, 8'hDE; err_count=0.
- ALU model with op 101 stuck-at 8'h00, A=8'h23, B=8'h45 → only the op-5 report has mismatch=1 (res_data=00, res_expected=68); final err_count=1.
- S=3: alu_op is stable 3 cycles per op; first res_valid at cycle 4, done at cycle 29; start pulses while busy cause no restart and no operand change.
- rst asserted during the DRIVE of op 3 → next cycle all outputs 0 and busy=0; a fresh start then yields a full 7-report sequence from op 0.
- A=8'hFF, B=8'hFF → mul 8'hE1, add 8'hFE, sub 8'h00 (wrap and carry discard).
